// File: rtl/bram_dual_port_responder.sv
// True dual-port BRAM model with zero-fill on reset, host side-port,
// configurable read latency and sticky error flags.
module bram_dual_port_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] address0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic                  ce1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] address1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] din1,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_grant,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_ready,
  output logic                  err_oob,
  output logic                  err_collision
);

  localparam int IW = $clog2(DEPTH);
  localparam int RL = READ_LATENCY;

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_clear_ptr;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_run;
  logic                  w_a_en;
  logic                  w_a_we;
  logic                  w_a_host;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [DATA_WIDTH-1:0] w_a_wd;
  logic                  w_a_oob;
  logic [IW-1:0]         w_a_idx;
  logic                  w_a_wr;
  logic                  w_a_rd;
  logic [DATA_WIDTH-1:0] w_a_rdata;

  logic                  w_b_en;
  logic                  w_b_oob;
  logic [IW-1:0]         w_b_idx;
  logic                  w_b_wr;
  logic                  w_b_rd;
  logic [DATA_WIDTH-1:0] w_b_rdata;

  logic                  w_coll;
  logic                  w_any_oob;

  logic [RL-1:0]         r_a_v;
  logic [RL-1:0]         r_a_h;
  logic [DATA_WIDTH-1:0] r_a_d [RL];
  logic [RL-1:0]         r_b_v;
  logic [DATA_WIDTH-1:0] r_b_d [RL];

  assign w_run      = (r_state == S_RUN);
  assign mem_ready  = w_run;
  assign host_grant = w_run & host_req & ~ce0;

  // Port A is port 0, or the host when port 0 is idle.
  assign w_a_en    = w_run & (ce0 | host_req);
  assign w_a_host  = ~ce0;
  assign w_a_we    = ce0 ? we0 : host_we;
  assign w_a_addr  = ce0 ? address0 : host_addr;
  assign w_a_wd    = ce0 ? dout0 : host_wdata;
  assign w_a_oob   = 64'(w_a_addr) >= 64'(DEPTH);
  assign w_a_idx   = w_a_addr[IW-1:0];
  assign w_a_wr    = w_a_en & w_a_we & ~w_a_oob;
  assign w_a_rd    = w_a_en & ~w_a_we;
  assign w_a_rdata = w_a_oob ? '0 : r_mem[w_a_idx];

  assign w_b_en    = w_run & ce1;
  assign w_b_oob   = 64'(address1) >= 64'(DEPTH);
  assign w_b_idx   = address1[IW-1:0];
  assign w_b_wr    = w_b_en & we1 & ~w_b_oob;
  assign w_b_rd    = w_b_en & ~we1;
  assign w_b_rdata = w_b_oob ? '0 : r_mem[w_b_idx];

  assign w_coll    = w_a_wr & w_b_wr & (w_a_idx == w_b_idx);
  assign w_any_oob = (w_a_en & w_a_oob) | (w_b_en & w_b_oob);

  // Next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_CLEAR: begin
        if (r_clear_ptr == IW'(DEPTH - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // State register and zero-fill pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_CLEAR;
      r_clear_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) begin
        r_clear_ptr <= r_clear_ptr + 1'b1;
      end
    end
  end

  // Storage: zero-fill in CLEAR, port writes in RUN (port 1 wins ties).
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clear_ptr] <= '0;
      end else begin
        if (w_a_wr) begin
          r_mem[w_a_idx] <= w_a_wd;
        end
        if (w_b_wr) begin
          r_mem[w_b_idx] <= dout1;
        end
      end
    end
  end

  // Read pipelines: data captured at request edge, shifted RL stages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a_v <= '0;
      r_a_h <= '0;
      r_b_v <= '0;
      for (int k = 0; k < RL; k++) begin
        r_a_d[k] <= '0;
        r_b_d[k] <= '0;
      end
    end else begin
      r_a_v[0] <= w_a_rd;
      r_a_h[0] <= w_a_host;
      r_a_d[0] <= w_a_rdata;
      r_b_v[0] <= w_b_rd;
      r_b_d[0] <= w_b_rdata;
      for (int k = 1; k < RL; k++) begin
        r_a_v[k] <= r_a_v[k-1];
        r_a_h[k] <= r_a_h[k-1];
        r_a_d[k] <= r_a_d[k-1];
        r_b_v[k] <= r_b_v[k-1];
        r_b_d[k] <= r_b_d[k-1];
      end
    end
  end

  // Read completion: steer port A results to din0 or the host.
  always_ff @(posedge clk) begin
    if (!rst) begin
      din0        <= '0;
      din1        <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      if (r_a_v[RL-1]) begin
        if (r_a_h[RL-1]) begin
          host_rdata  <= r_a_d[RL-1];
          host_rvalid <= 1'b1;
        end else begin
          din0 <= r_a_d[RL-1];
        end
      end
      if (r_b_v[RL-1]) begin
        din1 <= r_b_d[RL-1];
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_oob       <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      if (w_any_oob) begin
        err_oob <= 1'b1;
      end
      if (w_coll) begin
        err_collision <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bram_dual_port_responder.sv
// Directed bench for bram_dual_port_responder
// DEPTH=16, READ_LATENCY=3.
module tb_bram_dual_port_responder;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic          ce0, we0, ce1, we1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] dout0, dout1, din0, din1;
  logic          host_req, host_we, host_grant, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_ready, err_oob, err_collision;

  int n_pass;
  int n_total;

  bram_dual_port_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(16),
    .READ_LATENCY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .ce0(ce0), .we0(we0), .address0(address0),
    .dout0(dout0), .din0(din0),
    .ce1(ce1), .we1(we1), .address1(address1),
    .dout1(dout1), .din1(din1),
    .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_grant(host_grant), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .mem_ready(mem_ready),
    .err_oob(err_oob), .err_collision(err_collision)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ce0 = 0; we0 = 0; address0 = '0; dout0 = '0;
    ce1 = 0; we1 = 0; address1 = '0; dout1 = '0;
    host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0;
  endtask

  task automatic wr1(input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    ce1 = 1; we1 = 1; address1 = a; dout1 = d;
    @(negedge clk);
    ce1 = 0; we1 = 0;
  endtask

  task automatic rd0(input logic [AW-1:0] a,
                     output logic [DW-1:0] d);
    ce0 = 1; we0 = 0; address0 = a;
    @(negedge clk);
    ce0 = 0;
    repeat (3) @(negedge clk);
    d = din0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    rst = 0;
    idle();
    repeat (2) @(negedge clk);
    n_total++;
    if ({din0, din1, host_rdata} !== '0) begin
      $display("FAIL reset_data: got %h %h %h want 0",
               din0, din1, host_rdata);
    end else n_pass++;
    n_total++;
    if ({host_rvalid, mem_ready, err_oob, err_collision} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000",
               {host_rvalid, mem_ready, err_oob, err_collision});
    end else n_pass++;
    rst = 1;
    ce0 = 1; we0 = 1; address0 = 3; dout0 = 32'h77;
    ce1 = 1; we1 = 1; address1 = 20; dout1 = 32'h88;
    host_req = 1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_total++;
        ce0 = 0;
        #1;
        if (host_grant !== 1'b0) begin
          $display("FAIL clear_grant: got %b want 0", host_grant);
        end else n_pass++;
        ce0 = 1;
      end
      if (i == 15) begin
        n_total++;
        if (mem_ready !== 1'b0) begin
          $display("FAIL ready_early: got %b want 0", mem_ready);
        end else n_pass++;
      end
      if (i == 16) begin
        n_total++;
        if (mem_ready !== 1'b1) begin
          $display("FAIL ready_16: got %b want 1", mem_ready);
        end else n_pass++;
      end
    end
    idle();
    n_total++;
    if ({err_oob, err_collision} !== 2'b00) begin
      $display("FAIL clear_errs: got %b want 00",
               {err_oob, err_collision});
    end else n_pass++;
    for (int a = 0; a < 16; a++) begin
      rd0(AW'(a), d);
      n_total++;
      if (d !== '0) begin
        $display("FAIL zero_fill[%0d]: got %h want 0", a, d);
      end else n_pass++;
    end
  endtask

  task automatic test_latency();
    wr1(5, 32'hDEADBEEF);
    ce0 = 1; we0 = 0; address0 = 5;
    @(negedge clk);
    ce0 = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if (din0 !== 32'h0) begin
      $display("FAIL lat_t2: got %h want 0", din0);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (din0 !== 32'hDEADBEEF) begin
      $display("FAIL lat_t3: got %h want deadbeef", din0);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if (din0 !== 32'hDEADBEEF) begin
      $display("FAIL lat_hold: got %h want deadbeef", din0);
    end else n_pass++;
    ce1 = 1; we1 = 0; address1 = 5;
    @(negedge clk);
    ce1 = 0;
    repeat (3) @(negedge clk);
    n_total++;
    if (din1 !== 32'hDEADBEEF) begin
      $display("FAIL lat_p1: got %h want deadbeef", din1);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [3];
    exp[0] = 32'h101;
    exp[1] = 32'h202;
    exp[2] = 32'h303;
    for (int i = 0; i < 3; i++) begin
      wr1(AW'(i + 1), exp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      ce0 = 1; we0 = 0; address0 = AW'(i + 1);
      @(negedge clk);
    end
    ce0 = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (din0 !== exp[i]) begin
        $display("FAIL b2b[%0d]: got %h want %h", i, din0, exp[i]);
      end else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_rbw_collision();
    logic [DW-1:0] d;
    wr1(7, 32'h11);
    ce0 = 1; we0 = 0; address0 = 7;
    ce1 = 1; we1 = 1; address1 = 7; dout1 = 32'h22;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    n_total++;
    if (din0 !== 32'h11) begin
      $display("FAIL rbw_old: got %h want 11", din0);
    end else n_pass++;
    rd0(7, d);
    n_total++;
    if (d !== 32'h22) begin
      $display("FAIL rbw_new: got %h want 22", d);
    end else n_pass++;
    n_total++;
    if (err_collision !== 1'b0) begin
      $display("FAIL coll_pre: got %b want 0", err_collision);
    end else n_pass++;
    ce0 = 1; we0 = 1; address0 = 7; dout0 = 32'hAA;
    ce1 = 1; we1 = 1; address1 = 7; dout1 = 32'hBB;
    @(negedge clk);
    idle();
    n_total++;
    if (err_collision !== 1'b1) begin
      $display("FAIL coll_flag: got %b want 1", err_collision);
    end else n_pass++;
    rd0(7, d);
    n_total++;
    if (d !== 32'hBB) begin
      $display("FAIL coll_data: got %h want bb", d);
    end else n_pass++;
  endtask

  task automatic test_oob();
    logic [DW-1:0] d;
    wr1(4, 32'h44);
    n_total++;
    if (err_oob !== 1'b0) begin
      $display("FAIL oob_pre: got %b want 0", err_oob);
    end else n_pass++;
    wr1(20, 32'h55);
    n_total++;
    if (err_oob !== 1'b1) begin
      $display("FAIL oob_flag: got %b want 1", err_oob);
    end else n_pass++;
    rd0(4, d);
    n_total++;
    if (d !== 32'h44) begin
      $display("FAIL oob_alias: got %h want 44", d);
    end else n_pass++;
    rd0(20, d);
    n_total++;
    if (d !== 32'h0) begin
      $display("FAIL oob_read: got %h want 0", d);
    end else n_pass++;
  endtask

  task automatic test_host();
    logic [DW-1:0] d;
    rd0(5, d);
    ce0 = 1; we0 = 0; address0 = 5;
    host_req = 1; host_we = 1;
    host_addr = 9; host_wdata = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (host_grant !== 1'b0) begin
        $display("FAIL host_block[%0d]: got %b want 0", i, host_grant);
      end else n_pass++;
      @(negedge clk);
    end
    ce0 = 0;
    #1;
    n_total++;
    if (host_grant !== 1'b1) begin
      $display("FAIL host_grant_w: got %b want 1", host_grant);
    end else n_pass++;
    @(negedge clk);
    host_we = 0;
    #1;
    n_total++;
    if (host_grant !== 1'b1) begin
      $display("FAIL host_grant_r: got %b want 1", host_grant);
    end else n_pass++;
    @(negedge clk);
    host_req = 0;
    repeat (2) @(negedge clk);
    n_total++;
    if (host_rvalid !== 1'b0) begin
      $display("FAIL hrv_early: got %b want 0", host_rvalid);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({host_rvalid, host_rdata} !== {1'b1, 32'h99}) begin
      $display("FAIL hrv_data: got %b %h want 1 99",
               host_rvalid, host_rdata);
    end else n_pass++;
    @(negedge clk);
    n_total++;
    if ({host_rvalid, host_rdata} !== {1'b0, 32'h99}) begin
      $display("FAIL hrv_pulse: got %b %h want 0 99",
               host_rvalid, host_rdata);
    end else n_pass++;
    n_total++;
    if (din0 !== 32'hDEADBEEF) begin
      $display("FAIL host_din0: got %h want deadbeef", din0);
    end else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] d;
    logic          seen;
    seen = 0;
    ce0 = 1; we0 = 0; address0 = 5;
    ce1 = 1; we1 = 0; address1 = 9;
    @(negedge clk);
    idle();
    host_req = 1; host_we = 0; host_addr = 9;
    @(negedge clk);
    host_req = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    n_total++;
    if ({err_oob, err_collision} !== 2'b00) begin
      $display("FAIL mid_errs: got %b want 00",
               {err_oob, err_collision});
    end else n_pass++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host_rvalid) seen = 1;
    end
    n_total++;
    if ({seen, din0, din1} !== '0) begin
      $display("FAIL mid_flush: got %b %h %h want 0 0 0",
               seen, din0, din1);
    end else n_pass++;
    for (int i = 0; i < 40 && !mem_ready; i++) begin
      @(negedge clk);
    end
    n_total++;
    if (mem_ready !== 1'b1) begin
      $display("FAIL mid_ready: got %b want 1", mem_ready);
    end else n_pass++;
    rd0(5, d);
    n_total++;
    if (d !== '0) begin
      $display("FAIL mid_zero5: got %h want 0", d);
    end else n_pass++;
    rd0(9, d);
    n_total++;
    if (d !== '0) begin
      $display("FAIL mid_zero9: got %h want 0", d);
    end else n_pass++;
  endtask

  initial begin
    clk = 0;
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_rbw_collision();
    test_oob();
    test_host();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
